// File: rtl/hit_test_pipe.sv
// hit_test_pipe: 4-stage valid/ready point-in-triangle test (edge cross products dotted with the face normal).
// Build option: define HIT_EDGE_INCLUSIVE_EN to count edge/vertex points as hits (>=0 instead of >0).
`default_nettype none

module hit_test_pipe #(
  parameter int WIDTH  = 32,
  parameter int Q_BITS = 10,
  parameter int TAG_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3*WIDTH-1:0]   in_p_hit,
  input  logic [3*WIDTH-1:0]   in_normal,
  input  logic [3*WIDTH-1:0]   in_v0,
  input  logic [3*WIDTH-1:0]   in_v1,
  input  logic [3*WIDTH-1:0]   in_v2,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_hit,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int PW = 2 * WIDTH;
  localparam int DW = 2 * WIDTH + 2;

  typedef logic signed [WIDTH-1:0] word_t;
  typedef logic signed [DW-1:0]    dot_t;
  typedef struct packed { word_t z; word_t y; word_t x; } vec_t;

  typedef struct packed {
    vec_t e0; vec_t e1; vec_t e2;
    vec_t p0; vec_t p1; vec_t p2;
    vec_t n;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    vec_t c0; vec_t c1; vec_t c2;
    vec_t n;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    dot_t d0; dot_t d1; dot_t d2;
    logic [TAG_W-1:0] tag;
  } s3_t;

  function automatic vec_t vsub(input vec_t a, input vec_t b);
    vec_t r;
    r.x = a.x - b.x;
    r.y = a.y - b.y;
    r.z = a.z - b.z;
    return r;
  endfunction

  // a*b - c*d at 2*WIDTH bits, rescaled to the fixed-point format
  function automatic word_t xprod(input word_t a, input word_t b, input word_t c, input word_t d);
    logic signed [PW-1:0] diff;
    diff = PW'(a) * PW'(b) - PW'(c) * PW'(d);
    return word_t'(diff >>> Q_BITS);
  endfunction

  function automatic vec_t vcross(input vec_t a, input vec_t b);
    vec_t r;
    r.x = xprod(a.y, b.z, a.z, b.y);
    r.y = xprod(a.z, b.x, a.x, b.z);
    r.z = xprod(a.x, b.y, a.y, b.x);
    return r;
  endfunction

  function automatic dot_t vdot(input vec_t a, input vec_t b);
    dot_t sum;
    sum = DW'(a.x) * DW'(b.x) + DW'(a.y) * DW'(b.y) + DW'(a.z) * DW'(b.z);
    return sum >>> Q_BITS;
  endfunction

  function automatic logic pass(input dot_t d);
`ifdef HIT_EDGE_INCLUSIVE_EN
    return !d[DW-1];
`else
    return !d[DW-1] && (|d);
`endif
  endfunction

  vec_t p_w, n_w, v0_w, v1_w, v2_w;
  assign p_w  = in_p_hit;
  assign n_w  = in_normal;
  assign v0_w = in_v0;
  assign v1_w = in_v1;
  assign v2_w = in_v2;

  logic v1_q, v2_q, v3_q, out_valid_q;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;
  logic hit_d, hit_q;
  logic [TAG_W-1:0] tag_q;

  // Each stage loads when empty or when its successor loads this cycle
  logic s1_ld, s2_ld, s3_ld, s4_ld;
  assign s4_ld    = !out_valid_q || out_ready;
  assign s3_ld    = !v3_q || s4_ld;
  assign s2_ld    = !v2_q || s3_ld;
  assign s1_ld    = !v1_q || s2_ld;
  assign in_ready = s1_ld;

  always_comb begin
    s1_d     = '0;
    s1_d.e0  = vsub(v1_w, v0_w);
    s1_d.e1  = vsub(v2_w, v1_w);
    s1_d.e2  = vsub(v0_w, v2_w);
    s1_d.p0  = vsub(p_w, v0_w);
    s1_d.p1  = vsub(p_w, v1_w);
    s1_d.p2  = vsub(p_w, v2_w);
    s1_d.n   = n_w;
    s1_d.tag = in_tag;
  end

  always_comb begin
    s2_d     = '0;
    s2_d.c0  = vcross(s1_q.e0, s1_q.p0);
    s2_d.c1  = vcross(s1_q.e1, s1_q.p1);
    s2_d.c2  = vcross(s1_q.e2, s1_q.p2);
    s2_d.n   = s1_q.n;
    s2_d.tag = s1_q.tag;
  end

  always_comb begin
    s3_d     = '0;
    s3_d.d0  = vdot(s2_q.c0, s2_q.n);
    s3_d.d1  = vdot(s2_q.c1, s2_q.n);
    s3_d.d2  = vdot(s2_q.c2, s2_q.n);
    s3_d.tag = s2_q.tag;
  end

  always_comb begin
    hit_d = pass(s3_q.d0) && pass(s3_q.d1) && pass(s3_q.d2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      s1_q <= '0;
    end else begin
      if (s1_ld) v1_q <= in_valid;
      if (s1_ld && in_valid) s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0;
      s2_q <= '0;
    end else begin
      if (s2_ld) v2_q <= v1_q;
      if (s2_ld && v1_q) s2_q <= s2_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q <= 1'b0;
      s3_q <= '0;
    end else begin
      if (s3_ld) v3_q <= v2_q;
      if (s3_ld && v2_q) s3_q <= s3_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      tag_q       <= '0;
    end else begin
      if (s4_ld) out_valid_q <= v3_q;
      if (s4_ld && v3_q) begin
        hit_q <= hit_d;
        tag_q <= s3_q.tag;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_hit   = hit_q;
  assign out_tag   = tag_q;

endmodule

`default_nettype wire

// File: tb/tb_hit_test_pipe.sv
// tb_hit_test_pipe: directed table, streaming/backpressure/reset sequences and random traffic vs. a reference model.
`default_nettype none

module tb_hit_test_pipe;

  localparam int W  = 32;
  localparam int QB = 10;
  localparam int TW = 8;
`ifdef HIT_EDGE_INCLUSIVE_EN
  localparam bit EDGE_EXP = 1'b1;
`else
  localparam bit EDGE_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3*W-1:0] in_p_hit, in_normal, in_v0, in_v1, in_v2;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic          out_hit;
  logic [TW-1:0] out_tag;

  hit_test_pipe #(.WIDTH(W), .Q_BITS(QB), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p_hit(in_p_hit), .in_normal(in_normal),
    .in_v0(in_v0), .in_v1(in_v1), .in_v2(in_v2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hit(out_hit), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3*W-1:0] p, n, v0, v1, v2;
    bit             exp;
  } vec_rec_t;

  typedef struct { logic [TW-1:0] tag; bit hit; } exp_t;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  logic [TW-1:0] cur_tag;
  bit   cur_exp;
  int   cyc = 0;
  int   ov_cnt, first_ov, last_ov;
  bit   prev_ov = 0, prev_or = 0, prev_hit = 0;
  logic [TW-1:0] prev_tag = '0;
  bit   last_acc, saw_full;
  logic [TW-1:0] ntag = 8'h80;

  function automatic logic [3*W-1:0] pk(input longint x, input longint y, input longint z);
    logic [63:0] a, b, c;
    a = x; b = y; c = z;
    return {c[W-1:0], b[W-1:0], a[W-1:0]};
  endfunction

  function automatic longint comp(input logic [3*W-1:0] v, input int k);
    logic signed [W-1:0] s;
    s = v[k*W +: W];
    return longint'(s);
  endfunction

  // Inside iff the point lies on the inner side of all three directed edges w.r.t. the normal
  function automatic bit hit_ref(input logic [3*W-1:0] p, n, a, b, c);
    longint P[3], N[3], V[3][3], E[3], R[3], C[3], d;
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      P[k] = comp(p, k); N[k] = comp(n, k);
      V[0][k] = comp(a, k); V[1][k] = comp(b, k); V[2][k] = comp(c, k);
    end
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        E[k] = V[(i + 1) % 3][k] - V[i][k];
        R[k] = P[k] - V[i][k];
      end
      C[0] = (E[1] * R[2] - E[2] * R[1]) >>> QB;
      C[1] = (E[2] * R[0] - E[0] * R[2]) >>> QB;
      C[2] = (E[0] * R[1] - E[1] * R[0]) >>> QB;
      d = (C[0] * N[0] + C[1] * N[1] + C[2] * N[2]) >>> QB;
      ok = ok && (EDGE_EXP ? (d >= 0) : (d > 0));
    end
    return ok;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic set_q(input vec_rec_t r, input logic [TW-1:0] tag);
    in_valid  = 1'b1;
    in_p_hit  = r.p;  in_normal = r.n;
    in_v0     = r.v0; in_v1     = r.v1; in_v2 = r.v2;
    in_tag    = tag;
    cur_tag   = tag;
    cur_exp   = r.exp;
  endtask

  task automatic gen_rand();
    vec_rec_t r;
    r.v0 = pk(longint'($urandom_range(4000)) - 2000, longint'($urandom_range(4000)) - 2000, longint'($urandom_range(1000)) - 500);
    r.v1 = pk(longint'($urandom_range(4000)) - 2000, longint'($urandom_range(4000)) - 2000, longint'($urandom_range(1000)) - 500);
    r.v2 = pk(longint'($urandom_range(4000)) - 2000, longint'($urandom_range(4000)) - 2000, longint'($urandom_range(1000)) - 500);
    r.n  = pk(longint'($urandom_range(4096)) - 2048, longint'($urandom_range(4096)) - 2048, longint'($urandom_range(4096)) - 2048);
    r.p  = pk(longint'($urandom_range(4000)) - 2000, longint'($urandom_range(4000)) - 2000, longint'($urandom_range(1000)) - 500);
    r.exp = hit_ref(r.p, r.n, r.v0, r.v1, r.v2);
    set_q(r, ntag);
    ntag++;
  endtask

  // Observe at the falling edge, then step past the next rising edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    last_acc = 1'b0;
    if (rst_n) begin
      chk("in_ready", longint'(in_ready), longint'((sb.size() < 4) || out_ready));
      if (!in_ready) saw_full = 1'b1;
      if (prev_ov && !prev_or) begin
        chk("stall_valid", longint'(out_valid), 1);
        chk("stall_tag", longint'(out_tag), longint'(prev_tag));
        chk("stall_hit", longint'(out_hit), longint'(prev_hit));
      end
      if (out_valid) begin
        ov_cnt++;
        if (first_ov < 0) first_ov = cyc;
        last_ov = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", longint'(out_tag), -1);
        end else begin
          e = sb.pop_front();
          chk("out_tag", longint'(out_tag), longint'(e.tag));
          chk("out_hit", longint'(out_hit), longint'(e.hit));
        end
      end
      if (in_valid && in_ready) begin
        e.tag = cur_tag; e.hit = cur_exp;
        sb.push_back(e);
        last_acc = 1'b1;
      end
      prev_ov = out_valid; prev_or = out_ready;
      prev_tag = out_tag;  prev_hit = out_hit;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    ov_cnt = 0; first_ov = -1; last_ov = -1;
  endtask

  vec_rec_t tbl[6];
  int acc_cyc;

  initial begin
    tbl[0] = '{pk(256, 256, 0),   pk(0, 0, 1024),  pk(0, 0, 0), pk(1024, 0, 0), pk(0, 1024, 0), 1'b1};
    tbl[1] = '{pk(1024, 1024, 0), pk(0, 0, 1024),  pk(0, 0, 0), pk(1024, 0, 0), pk(0, 1024, 0), 1'b0};
    tbl[2] = '{pk(256, 256, 0),   pk(0, 0, -1024), pk(0, 0, 0), pk(1024, 0, 0), pk(0, 1024, 0), 1'b0};
    tbl[3] = '{pk(512, 0, 0),     pk(0, 0, 1024),  pk(0, 0, 0), pk(1024, 0, 0), pk(0, 1024, 0), EDGE_EXP};
    tbl[4] = '{pk(0, 0, 0),       pk(0, 0, 1024),  pk(0, 0, 0), pk(1024, 0, 0), pk(0, 1024, 0), EDGE_EXP};
    tbl[5] = '{pk(300, 300, 0),   pk(0, 0, 1024),  pk(0, 0, 0), pk(1024, 0, 0), pk(0, 1024, 0), 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_p_hit = '0; in_normal = '0; in_v0 = '0; in_v1 = '0; in_v2 = '0; in_tag = '0;
    cur_tag = '0; cur_exp = 1'b0; saw_full = 1'b0; last_acc = 1'b0;
    clr_mon();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_hit", longint'(out_hit), 0);
    chk("rst_out_tag", longint'(out_tag), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    rst_n = 1'b1;
    tick();

    // Directed vectors, one at a time, with latency check
    for (int i = 0; i < 6; i++) begin
      clr_mon();
      set_q(tbl[i], 8'h11 + 8'(i));
      tick();
      acc_cyc = cyc;
      in_valid = 1'b0;
      for (int k = 0; k < 10 && first_ov < 0; k++) tick();
      chk("latency", longint'(first_ov - acc_cyc), 4);
    end

    // Back-to-back stream, alternating interior and miss
    repeat (3) tick();
    clr_mon();
    for (int i = 0; i < 8; i++) begin
      set_q(tbl[i % 2], 8'(i));
      tick();
      if (i == 0) acc_cyc = cyc;
    end
    in_valid = 1'b0;
    repeat (8) tick();
    chk("stream_count", longint'(ov_cnt), 8);
    chk("stream_first", longint'(first_ov - acc_cyc), 4);
    chk("stream_span", longint'(last_ov - first_ov), 7);

    // Backpressure: out_ready low for 6 cycles while streaming
    saw_full = 1'b0;
    gen_rand();
    for (int i = 0; i < 24; i++) begin
      out_ready = !(i >= 4 && i < 10);
      tick();
      if (last_acc) gen_rand();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    chk("bp_saw_full", longint'(saw_full), 1);
    chk("bp_drained", longint'(sb.size()), 0);

    // Reset with three queries in flight
    for (int i = 0; i < 3; i++) begin
      set_q(tbl[0], 8'hA0 + 8'(i));
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_tag", longint'(out_tag), 0);
    chk("mid_rst_ready", longint'(in_ready), 1);
    sb.delete();
    prev_ov = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_mon();
    repeat (10) tick();
    chk("mid_rst_no_out", longint'(ov_cnt), 0);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || last_acc) begin
        if ($urandom_range(99) < 75) gen_rand();
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(99) < 70);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) tick();
    chk("final_drained", longint'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
